// File: rtl/mem_stage_if.sv
// Data-memory bus between the MEM stage (master) and a variable-latency memory (slave).
// req stays high for the whole access; ack is a single-cycle completion pulse.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage RISC-V pipeline: req/ack data-memory access with timeout abort,
// upstream stall and MEM/WB registers. Optional alignment check: MEM_STAGE_MISALIGN_CHECK_EN.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      alu_result_in,
  input  logic [31:0]      reg2_in,
  input  logic [4:0]       rd_in,
  input  logic             mem_read_in,
  input  logic             mem_write_in,
  input  logic             reg_write_in,
  input  logic             mem_to_reg_in,
  mem_stage_if.master      dmem,
  output logic             stall,
  output logic [31:0]      alu_result_out,
  output logic [31:0]      mem_data_out,
  output logic [4:0]       rd_out,
  output logic             reg_write_out,
  output logic             mem_to_reg_out,
  output logic             bus_err,
  output logic             misalign_err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             bus_err_r;
  logic             misalign_err_r;

  logic             mem_op_s;
  logic             in_access_s;
  logic             timeout_hit_s;
  logic             read_done_s;
  logic             misalign_s;
  logic             stall_s;

  // Access decode, timeout detection and upstream stall
  always_comb begin
    mem_op_s      = mem_read_in | mem_write_in;
    in_access_s   = (state_r == ACCESS);
    timeout_hit_s = in_access_s & ~dmem.dmem_ack & (cnt_r == CNT_LAST);
    // A read+write combination is a write, so it never loads data.
    read_done_s   = in_access_s & dmem.dmem_ack & mem_read_in & ~mem_write_in;
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
    misalign_s    = (state_r == IDLE) & mem_op_s & (alu_result_in[1:0] != 2'b00);
`else
    misalign_s    = 1'b0;
`endif
    stall_s       = mem_op_s & ~misalign_s & ~(in_access_s & (dmem.dmem_ack | timeout_hit_s));
  end

  assign stall           = stall_s;
  assign dmem.dmem_req   = in_access_s;
  assign dmem.dmem_we    = mem_write_in;
  assign dmem.dmem_addr  = alu_result_in;
  assign dmem.dmem_wdata = reg2_in;
  assign bus_err         = bus_err_r;
  assign misalign_err    = misalign_err_r;

  // Access FSM with its ACCESS-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          if (mem_op_s & ~misalign_s) begin
            state_r <= ACCESS;
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (dmem.dmem_ack | timeout_hit_s) begin
            state_r <= IDLE;
            cnt_r   <= '0;
          end else begin
            state_r <= ACCESS;
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  // MEM/WB pipeline registers and error pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_result_out <= 32'h0000_0000;
      mem_data_out   <= 32'h0000_0000;
      rd_out         <= 5'd0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      bus_err_r      <= 1'b0;
      misalign_err_r <= 1'b0;
    end else begin
      bus_err_r      <= timeout_hit_s;
      misalign_err_r <= misalign_s;
      if (stall_s) begin
        rd_out         <= 5'd0;
        reg_write_out  <= 1'b0;
        mem_to_reg_out <= 1'b0;
      end else if (timeout_hit_s | misalign_s) begin
        // Aborted or rejected accesses retire without any write-back.
        alu_result_out <= alu_result_in;
        rd_out         <= misalign_s ? 5'd0 : rd_in;
        reg_write_out  <= 1'b0;
        mem_to_reg_out <= 1'b0;
      end else begin
        alu_result_out <= alu_result_in;
        rd_out         <= rd_in;
        reg_write_out  <= reg_write_in;
        mem_to_reg_out <= mem_to_reg_in;
        if (read_done_s) begin
          mem_data_out <= dmem.dmem_rdata;
        end else begin
          mem_data_out <= mem_data_out;
        end
      end
    end
  end

endmodule
